// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: multiply/divide opcode encoding and helpers.
package cpu_types_pkg;

  localparam int MULDIV_OP_W = 3;

  typedef enum logic [MULDIV_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } muldiv_op_t;

  // True for the opcodes that launch a multi-cycle iteration.
  function automatic logic is_muldiv_op(input muldiv_op_t op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // True for the divide opcodes.
  function automatic logic is_div_op(input muldiv_op_t op);
    case (op)
      MD_DIV, MD_DIVU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// mode_div=0: BITS_PER_CYCLE shift-add steps (acc += mcand when the
//             multiplier LSB is set; mcand shifts left, multiplier right).
// mode_div=1: BITS_PER_CYCLE restoring-division steps on {rem, quotient}
//             held in acc, divisor held in mcand[WIDTH-1:0].
module muldiv_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   acc_nxt,
  output logic [2*WIDTH-1:0]   mcand_nxt,
  output logic [WIDTH-1:0]     mplier_nxt
);

  logic [WIDTH:0] rem_s;
  logic [WIDTH:0] diff_s;

  // Unrolled BITS_PER_CYCLE-step iteration for the selected mode.
  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    rem_s      = {(WIDTH+1){1'b0}};
    diff_s     = {(WIDTH+1){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mode_div) begin
        // Partial remainder after shifting in the next dividend bit; one
        // extra bit so the borrow of the trial subtract is visible.
        rem_s  = {acc_nxt[2*WIDTH-1:WIDTH], acc_nxt[WIDTH-1]};
        diff_s = rem_s - {1'b0, mcand_nxt[WIDTH-1:0]};
        if (!diff_s[WIDTH]) begin
          acc_nxt = {diff_s[WIDTH-1:0], acc_nxt[WIDTH-2:0], 1'b1};
        end else begin
          acc_nxt = {acc_nxt[2*WIDTH-2:0], 1'b0};
        end
      end else begin
        if (mplier_nxt[0]) begin
          acc_nxt = acc_nxt + mcand_nxt;
        end else begin
          acc_nxt = acc_nxt;
        end
        mcand_nxt  = {mcand_nxt[2*WIDTH-2:0], 1'b0};
        mplier_nxt = {1'b0, mplier_nxt[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit owning the HI/LO registers.
// Optional build macro: MULDIV_EARLY_OUT_EN lets a multiply leave the
// iteration as soon as the remaining multiplier bits are all zero.
module exe_muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  muldiv_op_t        op,
  input  logic [WIDTH-1:0]  porta,
  input  logic [WIDTH-1:0]  portb,
  input  logic              flush,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic              div_zero,
  output logic [WIDTH-1:0]  mf_data,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int N_ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_FIXUP = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r, mcand_r;
  logic [WIDTH-1:0]     mplier_r;          // multiplier, or raw dividend for a divide
  logic                 is_div_r, neg_lo_r, neg_hi_r, dz_pend_r;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 done_r, div_zero_r;

  logic [2*WIDTH-1:0]   acc_nxt_s, mcand_nxt_s;
  logic [WIDTH-1:0]     mplier_nxt_s;
  logic                 op_signed_s, sa_s, sb_s, launch_s, idle_start_s, early_s, wr_s;
  logic [WIDTH-1:0]     mag_a_s, mag_b_s, fix_hi_s, fix_lo_s;
  logic [2*WIDTH-1:0]   prod_s;

  // Two's-complement negate when neg is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Two's-complement negate over the double-width product.
  function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  muldiv_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .mode_div   (is_div_r),
    .acc        (acc_r),
    .mcand      (mcand_r),
    .mplier     (mplier_r),
    .acc_nxt    (acc_nxt_s),
    .mcand_nxt  (mcand_nxt_s),
    .mplier_nxt (mplier_nxt_s)
  );

  assign op_signed_s  = (op == MD_MULT) || (op == MD_DIV);
  assign sa_s         = op_signed_s & porta[WIDTH-1];
  assign sb_s         = op_signed_s & portb[WIDTH-1];
  assign mag_a_s      = neg_if(porta, sa_s);
  assign mag_b_s      = neg_if(portb, sb_s);
  // flush squashes whatever EX presents this cycle, including a new start.
  assign idle_start_s = start & ~flush & (state_r == ST_IDLE);
  assign launch_s     = idle_start_s & is_muldiv_op(op);
  assign wr_s         = (state_r == ST_FIXUP) & ~flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_s = ~is_div_r & (mplier_nxt_s == {WIDTH{1'b0}});
`else
  assign early_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: launch, count iterations, single fixup cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) state_nxt_s = ST_ITER;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ITER: begin
        if (flush)                                        state_nxt_s = ST_IDLE;
        else if ((cnt_r == {CNT_W{1'b0}}) || early_s)     state_nxt_s = ST_FIXUP;
        else                                              state_nxt_s = ST_ITER;
      end
      ST_FIXUP: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture on launch, then one datapath iteration per ITER cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_lo_r  <= 1'b0;
      neg_hi_r  <= 1'b0;
      dz_pend_r <= 1'b0;
    end else if (launch_s) begin
      cnt_r     <= CNT_W'(N_ITER - 1);
      is_div_r  <= is_div_op(op);
      neg_lo_r  <= sa_s ^ sb_s;
      neg_hi_r  <= sa_s;
      dz_pend_r <= is_div_op(op) & (portb == {WIDTH{1'b0}});
      mcand_r   <= {{WIDTH{1'b0}}, is_div_op(op) ? mag_b_s : mag_a_s};
      if (is_div_op(op)) begin
        acc_r    <= {{WIDTH{1'b0}}, mag_a_s};
        mplier_r <= porta;
      end else begin
        acc_r    <= {(2*WIDTH){1'b0}};
        mplier_r <= mag_b_s;
      end
    end else if (state_r == ST_ITER) begin
      cnt_r    <= cnt_r - CNT_W'(1);
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_nxt_s;
      mplier_r <= mplier_nxt_s;
    end
  end

  // Sign correction and divide-by-zero substitution of the final result.
  always_comb begin
    prod_s   = neg_if2(acc_r, neg_lo_r);
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      if (dz_pend_r) begin
        fix_hi_s = mplier_r;
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        fix_hi_s = neg_if(acc_r[2*WIDTH-1:WIDTH], neg_hi_r);
        fix_lo_s = neg_if(acc_r[WIDTH-1:0], neg_lo_r);
      end
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // HI/LO architectural registers plus registered completion flags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= wr_s;
      div_zero_r <= wr_s & is_div_r & dz_pend_r;
      if (wr_s) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
      end else if (idle_start_s && (op == MD_MTHI)) begin
        hi_r <= porta;
      end else if (idle_start_s && (op == MD_MTLO)) begin
        lo_r <= porta;
      end
    end
  end

  // Move-from read port; only meaningful while EX is not stalled.
  always_comb begin
    mf_data = {WIDTH{1'b0}};
    if (start) begin
      case (op)
        MD_MFHI: mf_data = hi_r;
        MD_MFLO: mf_data = lo_r;
        default: mf_data = {WIDTH{1'b0}};
      endcase
    end else begin
      mf_data = {WIDTH{1'b0}};
    end
  end

  assign busy     = (state_r != ST_IDLE);
  assign stall    = start & busy;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: three instances at 1, 2 and 4 bits
// per cycle, exercised one after another with the same scenario list.
module tb_exe_muldiv_unit;
  import cpu_types_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic         start_s [3];
  muldiv_op_t   op_s    [3];
  logic [W-1:0] porta_s [3];
  logic [W-1:0] portb_s [3];
  logic         flush_s [3];
  logic         busy_s  [3];
  logic         stall_s [3];
  logic         done_s  [3];
  logic         dz_s    [3];
  logic [W-1:0] mf_s    [3];
  logic [W-1:0] hi_s    [3];
  logic [W-1:0] lo_s    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    exe_muldiv_unit #(
      .WIDTH          (W),
      .BITS_PER_CYCLE (1 << g)
    ) u_dut (
      .CLK      (clk),
      .nRST     (nrst),
      .start    (start_s[g]),
      .op       (op_s[g]),
      .porta    (porta_s[g]),
      .portb    (portb_s[g]),
      .flush    (flush_s[g]),
      .busy     (busy_s[g]),
      .stall    (stall_s[g]),
      .done     (done_s[g]),
      .div_zero (dz_s[g]),
      .mf_data  (mf_s[g]),
      .hi       (hi_s[g]),
      .lo       (lo_s[g])
    );
  end

  exp_t         sb_q [$];
  int           checks_cnt = 0;
  int           errors_cnt = 0;
  logic [W-1:0] cur_hi [3];
  logic [W-1:0] cur_lo [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour written with plain language arithmetic.
  function automatic exp_t model(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    e = '0;
    p = 64'd0;
    case (o)
      MD_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = 32'd0; e.lo = 32'h8000_0000;
        end else begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic string tg(input int k, input string name);
    return $sformatf("bpc%0d_%s", 1 << k, name);
  endfunction

  // Launch one MULT/DIV and check latency and the result on done.
  task automatic run_op(input int k, input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   cyc;
    int   n;
    n = W >> k;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    start_s[k] = 1'b1; op_s[k] = o; porta_s[k] = a; portb_s[k] = b;
    #1 check(tg(k, "start_stall"), stall_s[k], 0);
    cyc = 0;
    do begin
      @(negedge clk);
      start_s[k] = 1'b0;
      cyc++;
    end while (!done_s[k] && cyc < n + 10);
    check(tg(k, "latency"), cyc, n + 2);
    e = sb_q.pop_front();
    check(tg(k, "hi"), hi_s[k], e.hi);
    check(tg(k, "lo"), lo_s[k], e.lo);
    check(tg(k, "div_zero"), dz_s[k], e.dz);
    cur_hi[k] = e.hi;
    cur_lo[k] = e.lo;
    @(negedge clk);
    check(tg(k, "done_pulse"), done_s[k], 0);
  endtask

  // MULT followed by an MFLO held on start until the interlock releases.
  task automatic run_mult_mf(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   cyc;
    int   stall_n;
    int   n;
    n = W >> k;
    sb_q.push_back(model(MD_MULT, a, b));
    @(negedge clk);
    start_s[k] = 1'b1; op_s[k] = MD_MULT; porta_s[k] = a; portb_s[k] = b;
    @(negedge clk);
    op_s[k] = MD_MFLO;
    cyc = 1;
    stall_n = 0;
    while (cyc < n + 10) begin
      #1;
      if (!stall_s[k]) break;
      stall_n++;
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    check(tg(k, "mf_release_cycle"), cyc, n + 2);
    check(tg(k, "mf_stall_cycles"), stall_n, n + 1);
    check(tg(k, "mf_data_lo"), mf_s[k], e.lo);
    check(tg(k, "mf_done"), done_s[k], 1);
    check(tg(k, "mf_hi"), hi_s[k], e.hi);
    cur_hi[k] = e.hi;
    cur_lo[k] = e.lo;
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  // MTHI/MTLO then MFHI/MFLO, all unstalled while idle.
  task automatic run_mt_mf(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_s[k] = 1'b1; op_s[k] = MD_MTHI; porta_s[k] = a;
    #1 check(tg(k, "mt_stall"), stall_s[k], 0);
    @(negedge clk);
    check(tg(k, "mthi"), hi_s[k], a);
    op_s[k] = MD_MTLO; porta_s[k] = b;
    @(negedge clk);
    check(tg(k, "mtlo"), lo_s[k], b);
    op_s[k] = MD_MFHI;
    #1 check(tg(k, "mfhi"), mf_s[k], a);
    check(tg(k, "mf_stall"), stall_s[k], 0);
    op_s[k] = MD_MFLO;
    #1 check(tg(k, "mflo"), mf_s[k], b);
    @(negedge clk);
    start_s[k] = 1'b0;
    cur_hi[k] = a;
    cur_lo[k] = b;
  endtask

  // Launch, flush at a given cycle after start (fcyc=0: same cycle as start).
  task automatic run_flush(input int k, input muldiv_op_t o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int fcyc, input string name);
    int n;
    int done_n;
    n = W >> k;
    @(negedge clk);
    start_s[k] = 1'b1; op_s[k] = o; porta_s[k] = a; portb_s[k] = b;
    flush_s[k] = (fcyc == 0);
    for (int c = 1; c <= fcyc; c++) begin
      @(negedge clk);
      start_s[k] = 1'b0;
      flush_s[k] = (c == fcyc);
    end
    @(negedge clk);
    start_s[k] = 1'b0;
    flush_s[k] = 1'b0;
    check(tg(k, {name, "_busy"}), busy_s[k], 0);
    done_n = 0;
    for (int c = 0; c < n + 4; c++) begin
      @(negedge clk);
      if (done_s[k]) done_n++;
    end
    check(tg(k, {name, "_no_done"}), done_n, 0);
    check(tg(k, {name, "_hi"}), hi_s[k], cur_hi[k]);
    check(tg(k, {name, "_lo"}), lo_s[k], cur_lo[k]);
  endtask

  initial begin
    int         n;
    muldiv_op_t rop;
    nrst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; op_s[k] = MD_MULT; porta_s[k] = '0; portb_s[k] = '0; flush_s[k] = 1'b0;
      cur_hi[k] = '0; cur_lo[k] = '0;
    end
    #22;
    for (int k = 0; k < 3; k++) begin
      check(tg(k, "rst_hi"), hi_s[k], 0);
      check(tg(k, "rst_lo"), lo_s[k], 0);
      check(tg(k, "rst_busy"), busy_s[k], 0);
      check(tg(k, "rst_stall"), stall_s[k], 0);
      check(tg(k, "rst_done"), done_s[k], 0);
      check(tg(k, "rst_dz"), dz_s[k], 0);
      check(tg(k, "rst_mf"), mf_s[k], 0);
    end
    @(negedge clk);
    nrst = 1'b1;

    for (int k = 0; k < 3; k++) begin
      n = W >> k;
      run_op(k, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(k, MD_MULT,  32'hFFFF_FFFD, 32'd7);
      run_op(k, MD_DIV,   32'hFFFF_FFF9, 32'd2);
      run_op(k, MD_DIVU,  32'd100,       32'd0);
      run_op(k, MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op(k, MD_DIV,   32'hFFFF_FF00, 32'd0);
      run_op(k, MD_DIVU,  32'hFFFF_FFFF, 32'd1);
      for (int i = 0; i < 4; i++) begin
        rop = muldiv_op_t'($urandom_range(3, 0));
        run_op(k, rop, $urandom, (i == 3) ? 32'($urandom_range(255, 1)) : $urandom);
      end
      run_mt_mf(k, 32'h1234_5678, 32'h9ABC_DEF0);
      run_mult_mf(k, 32'h0001_0003, 32'hFFFF_FFF0);
      run_flush(k, MD_DIV, 32'd1000, 32'd7, (n > 10) ? 10 : n / 2, "flush_iter");
      run_flush(k, MD_MULT, 32'd55, 32'd66, n + 1, "flush_fixup");
      run_flush(k, MD_MULTU, 32'd9, 32'd9, 0, "flush_start");
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start_s[0] = 1'b1; op_s[0] = MD_MULTU; porta_s[0] = 32'd3; portb_s[0] = 32'd5;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_busy", busy_s[0], 0);
    check("async_rst_hi", hi_s[0], 0);
    check("async_rst_lo", lo_s[0], 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit beside the execute-stage ALU.
- Owns the architectural HI/LO registers.
- Handles signed/unsigned MULT and DIV over multiple cycles, plus MFHI/MFLO/MTHI/MTLO.
- Raises a stall to the hazard unit while a dependent instruction must wait; supports pipeline flush mid-operation.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even.
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; legal values 1, 2, 4; must divide WIDTH.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- start  in  1  EX-stage instruction valid for this unit, qualified by op
- op  in  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
- porta  in  WIDTH  forwarded rs operand (multiplicand/dividend/MT source)
- portb  in  WIDTH  forwarded rt operand (multiplier/divisor)
- flush  in  1  squash in-flight operation (branch/jump mispredict)
- busy  out  1  iteration or fixup in progress
- stall  out  1  EX must hold; start/op/operands must stay stable while high
- done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV
- div_zero  out  1  pulses with done when a DIV/DIVU divisor was 0
- mf_data  out  WIDTH  HI or LO value for MFHI/MFLO, valid combinationally when stall=0
- hi  out  WIDTH  current HI register
- lo  out  WIDTH  current LO register

Behaviour:
- Reset: state=IDLE; hi=lo=0; busy=stall=done=div_zero=0; mf_data=0.
- States:
  - IDLE -> ITER on start with MULT/MULTU/DIV/DIVU.
  - ITER counts N=WIDTH/BITS_PER_CYCLE cycles, then -> FIXUP.
  - FIXUP (1 cycle) -> IDLE.
  - In FIXUP: sign correction, HI/LO write, done=1.
- Latency: the start cycle captures operands. HI/LO are visible from cycle N+2 after start. Example: WIDTH=32, BPC=1 gives 34.
- Operand capture: signed ops latch magnitudes and record result signs.
  - Product sign = sa^sb.
  - Quotient sign = sa^sb.
  - Remainder sign = sa.
- Multiply:
  - Shift-add on the 2*WIDTH magnitude product.
  - HI=upper WIDTH bits, LO=lower WIDTH bits.
  - Signed negation is applied to the full 2*WIDTH value.
- Divide:
  - Restoring division, BITS_PER_CYCLE quotient bits per cycle.
  - LO=quotient, HI=remainder.
- Divide by zero:
  - Full latency still taken.
  - LO=all ones, HI=porta as captured (unsigned original value), div_zero=1 with done.
- Signed overflow: DIV of -2^(W-1) by -1 gives LO=0x80000000, HI=0 (W=32).
- MTHI/MTLO in IDLE: write porta to HI/LO at the clock edge; stall=0.
- MFHI/MFLO in IDLE: mf_data=hi/lo the same cycle; stall=0.
- Interlock: stall=1 whenever start=1 and state!=IDLE. This covers MF/MT or a new MULT/DIV during an operation. EX holds until done; the held instruction proceeds in the cycle after FIXUP, reading updated HI/LO.
- The start cycle of MULT/DIV itself is not stalled: EX advances and the unit runs in the background.
- flush:
  - Any state -> IDLE next edge; HI/LO unchanged; done not pulsed.
  - flush in FIXUP still suppresses the write.
  - flush and start in the same cycle: flush wins, start ignored.
- Async reset mid-operation: immediately returns to reset values.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined:
  - Unsigned/magnitude multiply leaves ITER as soon as the remaining multiplier bits are zero.
  - Minimum 1 ITER cycle, e.g. 5*3 finishes in 2 ITER cycles at BPC=1.
  - Divide unchanged.
- Undefined: fixed N-cycle latency for all operations.

Decomposition:
- muldiv_op_t enum and MULDIV_OP_W=3 go in cpu_types_pkg.
- The state enum is local.
- One sub-module, muldiv_step: purely combinational. It performs one BITS_PER_CYCLE-bit iteration for both shift-add and restoring-subtract, selected by a mode input.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, BPC=1 -> done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU 100/0 -> div_zero pulse, LO=0xFFFFFFFF, HI=0x64.
- MULT then MFLO held on start during ITER:
  - stall=1 through FIXUP.
  - Next cycle stall=0 and mf_data equals the new LO.
- DIV in progress, flush at ITER cycle 10 -> IDLE next cycle, no done, HI/LO keep prior values.
- Repeat all scenarios with BPC=2 and BPC=4; latency is 18 and 10 cycles respectively.
